// File: rtl/dlfloat16_sqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : dlfloat16_sqrt_seq
// Function : Iterative DLFloat square root (default 1/6/9, bias 31).
//            Restoring digit recurrence, one root bit per clock, exact
//            rounding, invalid/inexact flags, valid/ready streaming.
// Options  : DLFLOAT_SQRT_RNE_EN defined   -> round to nearest even
//            DLFLOAT_SQRT_RNE_EN undefined -> truncate (round toward zero)
// Revision : 1.0  initial release
// ============================================================================
module dlfloat16_sqrt_seq #(
   parameter int EXP_W = 6,
   parameter int MAN_W = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_data,
   output logic                   out_inv,
   output logic                   out_inx
);

   localparam int W         = 1 + EXP_W + MAN_W;
   localparam int BIAS      = 2**(EXP_W-1) - 1;
   localparam int HALF_BIAS = BIAS / 2;
   localparam int QW        = MAN_W + 2;          // root width
   localparam int XW        = 2 * QW;             // radicand width
   localparam int RW        = MAN_W + 4;          // partial remainder width
   localparam int TW        = RW + 2;             // trial subtraction width
   localparam int CW        = $clog2(MAN_W+2) + 1;
   localparam logic [CW-1:0] LAST_ITER = CW'(MAN_W + 1);
   localparam logic [W-1:0]  QNAN      = {1'b0, {(W-1){1'b1}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CALC  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   logic [CW-1:0]       cnt_q;
   logic [XW-1:0]       x_q;
   logic [QW-1:0]       root_q;
   logic [RW-1:0]       rem_q;
   logic [EXP_W-1:0]    exp_q;
   logic                out_valid_q;
   logic [W-1:0]        out_data_q;
   logic                out_inv_q;
   logic                out_inx_q;

   // operand classification and initial datapath values
   logic                in_sign;
   logic [EXP_W-1:0]    in_exp;
   logic [MAN_W-1:0]    in_man;
   logic                in_is_zero;
   logic                in_is_nan;
   logic [XW-1:0]       x_init;
   logic [EXP_W-1:0]    exp_init;

   // recurrence step
   logic [TW-1:0]       trial_a;
   logic [TW-1:0]       trial_b;
   logic                trial_ge;
   logic [RW-1:0]       trial_sub;
   logic [RW-1:0]       rem_d;
   logic [QW-1:0]       root_d;

   // rounding
   logic                sticky;
   logic                rnd_bit;
   logic                round_up;
   logic [MAN_W:0]      man_sum;
   logic [EXP_W-1:0]    exp_d;

   // Classification, radicand alignment, recurrence step and final rounding
   always_comb begin
      in_sign    = in_data[W-1];
      in_exp     = in_data[W-2:MAN_W];
      in_man     = in_data[MAN_W-1:0];
      in_is_zero = (in_exp == '0);
      in_is_nan  = (in_data[W-2:0] == {(W-1){1'b1}});

      // Odd biased exponent means even unbiased exponent: shift one less so
      // the root always lands with its leading one at bit QW-1.
      x_init = {{(XW-MAN_W-1){1'b0}}, 1'b1, in_man};
      if (in_exp[0])
         x_init = x_init << (MAN_W + 2);
      else
         x_init = x_init << (MAN_W + 3);

      // (exp+BIAS)>>1 for odd exp and (exp+BIAS-1)>>1 for even exp both
      // reduce to exp[hi:1] + BIAS/2 + exp[0] because BIAS is odd.
      exp_init = {1'b0, in_exp[EXP_W-1:1]} + EXP_W'(HALF_BIAS)
               + {{(EXP_W-1){1'b0}}, in_exp[0]};

      // trial = 4*rem + next two radicand bits - (4*root + 1)
      trial_a   = {rem_q, x_q[XW-1 -: 2]};
      trial_b   = {2'b00, root_q, 2'b01};
      trial_ge  = (trial_a >= trial_b);
      trial_sub = trial_a[RW-1:0] - trial_b[RW-1:0];
      rem_d     = trial_ge ? trial_sub : trial_a[RW-1:0];
      root_d    = {root_q[QW-2:0], trial_ge};

      sticky  = (rem_q != '0);
      rnd_bit = root_q[0];
`ifdef DLFLOAT_SQRT_RNE_EN
      round_up = rnd_bit & (sticky | root_q[1]);
`else
      round_up = 1'b0;
`endif
      man_sum = {1'b0, root_q[MAN_W:1]} + {{MAN_W{1'b0}}, round_up};
      // carry out of the mantissa leaves man_sum[MAN_W-1:0] at zero
      exp_d   = exp_q + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
   end

   // Control FSM with registered datapath and outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         x_q         <= '0;
         root_q      <= '0;
         rem_q       <= '0;
         exp_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_inv_q   <= 1'b0;
         out_inx_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  if (in_is_zero) begin
                     out_data_q  <= {in_sign, {(W-1){1'b0}}};
                     out_inv_q   <= 1'b0;
                     out_inx_q   <= 1'b0;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else if (in_is_nan || in_sign) begin
                     out_data_q  <= QNAN;
                     out_inv_q   <= 1'b1;
                     out_inx_q   <= 1'b0;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     x_q     <= x_init;
                     root_q  <= '0;
                     rem_q   <= '0;
                     exp_q   <= exp_init;
                     cnt_q   <= '0;
                     state_q <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               x_q    <= x_q << 2;
               root_q <= root_d;
               rem_q  <= rem_d;
               if (cnt_q == LAST_ITER) begin
                  state_q <= S_ROUND;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_ROUND: begin
               out_data_q  <= {1'b0, exp_d, man_sum[MAN_W-1:0]};
               out_inv_q   <= 1'b0;
               out_inx_q   <= rnd_bit | sticky;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_inv   = out_inv_q;
   assign out_inx   = out_inx_q;

endmodule
`default_nettype wire

// File: tb/tb_dlfloat16_sqrt_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlfloat16_sqrt_seq
// Function : Self-checking bench for dlfloat16_sqrt_seq (default 1/6/9).
//            Honours DLFLOAT_SQRT_RNE_EN for the rounding expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_dlfloat16_sqrt_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_inv;
   logic        out_inx;

   int n_tests = 0;
   int n_fail  = 0;

   dlfloat16_sqrt_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_inv   (out_inv),
      .out_inx   (out_inx)
   );

   always #5 clk = ~clk;

   // Reference: value = (1.man) * 2^(exp-31); root computed with an integer
   // square root of the significand scaled so the root carries 11 bits.
   function automatic void model(input logic [15:0] d, output logic [15:0] r,
                                 output logic inv, output logic inx, output int lat);
      int     e, u, um, re, mant, g;
      longint sig, x, root;
      bit     st, up;
      e = int'(d[14:9]);
      inv = 1'b0; inx = 1'b0; lat = 1;
      if (e == 0) begin
         r = {d[15], 15'h0000};
      end else if (d[14:0] == 15'h7FFF || d[15]) begin
         r = 16'h7FFF; inv = 1'b1;
      end else begin
         lat  = 12;
         sig  = 512 + longint'(d[8:0]);
         u    = e - 31;
         um   = ((u % 2) + 2) % 2;
         re   = (u - um) / 2 + 31;
         x    = sig << (11 + um);
         root = longint'($floor($sqrt(real'(x))));
         while (root * root > x) root--;
         while ((root + 1) * (root + 1) <= x) root++;
         st   = (root * root != x);
         g    = int'(root % 2);
         mant = int'(root / 2) - 512;
         inx  = st || (g != 0);
`ifdef DLFLOAT_SQRT_RNE_EN
         up = (g != 0) && (st || (mant % 2 != 0));
`else
         up = 1'b0;
`endif
         if (up) mant++;
         if (mant == 512) begin mant = 0; re++; end
         r = {1'b0, 6'(re), 9'(mant)};
      end
   endfunction

   // Drive one operand, measure latency from the accept edge, optionally handshake
   task automatic run_op(input logic [15:0] d, input bit hs, output logic [15:0] r,
                         output logic inv, output logic inx, output int lat);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      lat = -1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            lat = c;
            break;
         end
      end
      r = out_data; inv = out_inv; inx = out_inx;
      if (hs && lat > 0) begin
         @(negedge clk);
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         out_ready = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_tests++;
      if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data got %h want 0000", out_data); end
      n_tests++;
      if ({out_inv, out_inx} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {out_inv, out_inx}); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
   endtask

   task automatic test_directed();
      logic [15:0] vin  [9];
      logic [15:0] vexp [9];
      logic [1:0]  vflg [9];   // {inv, inx}
      int          vlat [9];
      logic [15:0] r;
      logic        inv, inx;
      int          lat;
      vin[0] = 16'h3E00; vexp[0] = 16'h3E00; vflg[0] = 2'b00; vlat[0] = 12;
      vin[1] = 16'h4200; vexp[1] = 16'h4000; vflg[1] = 2'b00; vlat[1] = 12;
      vin[2] = 16'h4000; vexp[2] = 16'h3ED4; vflg[2] = 2'b01; vlat[2] = 12;
`ifdef DLFLOAT_SQRT_RNE_EN
      vin[3] = 16'h4100; vexp[3] = 16'h3F77; vflg[3] = 2'b01; vlat[3] = 12;
`else
      vin[3] = 16'h4100; vexp[3] = 16'h3F76; vflg[3] = 2'b01; vlat[3] = 12;
`endif
      vin[4] = 16'hC200; vexp[4] = 16'h7FFF; vflg[4] = 2'b10; vlat[4] = 1;
      vin[5] = 16'h8000; vexp[5] = 16'h8000; vflg[5] = 2'b00; vlat[5] = 1;
      vin[6] = 16'h0123; vexp[6] = 16'h0000; vflg[6] = 2'b00; vlat[6] = 1;
      vin[7] = 16'h7FFF; vexp[7] = 16'h7FFF; vflg[7] = 2'b10; vlat[7] = 1;
      vin[8] = 16'hFFFF; vexp[8] = 16'h7FFF; vflg[8] = 2'b10; vlat[8] = 1;
      for (int i = 0; i < 9; i++) begin
         run_op(vin[i], 1'b1, r, inv, inx, lat);
         n_tests++;
         if (r !== vexp[i]) begin n_fail++; $display("FAIL dir_data in=%h got %h want %h", vin[i], r, vexp[i]); end
         n_tests++;
         if ({inv, inx} !== vflg[i]) begin n_fail++; $display("FAIL dir_flags in=%h got %b want %b", vin[i], {inv, inx}, vflg[i]); end
         n_tests++;
         if (lat != vlat[i]) begin n_fail++; $display("FAIL dir_latency in=%h got %0d want %0d", vin[i], lat, vlat[i]); end
         n_tests++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL dir_in_ready_after_hs in=%h got %b want 1", vin[i], in_ready); end
      end
   endtask

   task automatic test_random();
      logic [15:0] d, r, er;
      logic        inv, inx, einv, einx;
      int          lat, elat;
      for (int i = 0; i < 150; i++) begin
         d = 16'($urandom);
         if ($urandom_range(3, 0) != 0) d[15] = 1'b0;
         model(d, er, einv, einx, elat);
         run_op(d, 1'b1, r, inv, inx, lat);
         n_tests++;
         if (r !== er || inv !== einv || inx !== einx || lat != elat) begin
            n_fail++;
            $display("FAIL rand in=%h got %h/%b%b/%0d want %h/%b%b/%0d",
                     d, r, inv, inx, lat, er, einv, einx, elat);
         end
      end
   endtask

   task automatic test_stall();
      logic [15:0] r;
      logic        inv, inx;
      int          lat;
      run_op(16'h4000, 1'b0, r, inv, inx, lat);
      n_tests++;
      if (lat != 12) begin n_fail++; $display("FAIL stall_latency got %0d want 12", lat); end
      // a competing operand must be ignored while the result is pending
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h4200;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         n_tests++;
         if (out_valid !== 1'b1 || out_data !== 16'h3ED4 || {out_inv, out_inx} !== 2'b01 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold cyc=%0d got v=%b d=%h f=%b rdy=%b want v=1 d=3ed4 f=01 rdy=0",
                     c, out_valid, out_data, {out_inv, out_inx}, in_ready);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_release got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      logic        inv, inx;
      int          lat;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h4100;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 16'h0000) begin
         n_fail++;
         $display("FAIL midrst_state got v=%b rdy=%b d=%h want v=0 rdy=1 d=0000", out_valid, in_ready, out_data);
      end
      @(negedge clk);
      rst = 1'b0;
      run_op(16'h4200, 1'b1, r, inv, inx, lat);
      n_tests++;
      if (r !== 16'h4000 || {inv, inx} !== 2'b00) begin
         n_fail++;
         $display("FAIL midrst_next got %h/%b want 4000/00", r, {inv, inx});
      end
      n_tests++;
      if (lat != 12) begin n_fail++; $display("FAIL midrst_latency got %0d want 12", lat); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_random();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
